// File: rtl/mu0_scan_pkg.sv
// Shared widths, frame layout and FSM encoding for the MU0 scan-path reader.
package mu0_scan_pkg;

    localparam int ACC_W    = 16;
    localparam int PC_W     = 12;
    localparam int FLAG_W   = 2;
    localparam int SCAN_LEN = ACC_W + PC_W + FLAG_W;

    localparam int ACC_LSB  = 0;
    localparam int PC_LSB   = ACC_LSB + ACC_W;
    localparam int FLAG_LSB = PC_LSB + PC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        SHIFT = 2'd2
    } scan_state_e;

endpackage

// File: rtl/mu0_scan_clkgen.sv
// Divides clk into a registered scan_clk (HALF cycles low, HALF high) with
// strobes flagging the clk edge on which scan_clk will rise or fall.
module mu0_scan_clkgen #(
    parameter int HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic scan_clk,
    output logic rise,
    output logic fall
);
    import mu0_scan_pkg::*;

    localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [DIV_W-1:0] div;
    logic             tick;

    assign tick = en && (div == DIV_W'(HALF - 1));
    assign rise = tick && !scan_clk;
    assign fall = tick && scan_clk;

    // Disabling parks the divider at the start of a low phase, so the first
    // pulse after enable is always a full HALF low then HALF high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div      <= '0;
            scan_clk <= 1'b0;
        end else if (!en) begin
            div      <= '0;
            scan_clk <= 1'b0;
        end else if (tick) begin
            div      <= '0;
            scan_clk <= ~scan_clk;
        end else begin
            div      <= div + 1'b1;
        end
    end

endmodule

// File: rtl/mu0_scan_reader.sv
// Debugger-side reader: pulses the MU0 scan path, deserialises one frame
// (acc, pc, flags) and publishes it with a start/busy/done handshake.
module mu0_scan_reader #(
    parameter int ACC_W  = mu0_scan_pkg::ACC_W,
    parameter int PC_W   = mu0_scan_pkg::PC_W,
    parameter int FLAG_W = mu0_scan_pkg::FLAG_W,
    parameter int HALF   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              snap_valid,
    output logic [ACC_W-1:0]  acc_q,
    output logic [PC_W-1:0]   pc_q,
    output logic [FLAG_W-1:0] flags_q,
    output logic              scan_clk,
    output logic              scan_en,
    input  logic              scan_out
);
    import mu0_scan_pkg::*;

    localparam int FRAME_W = ACC_W + PC_W + FLAG_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

    scan_state_e        state;
    logic [CNT_W-1:0]   count;
    logic               hi_seen;
    logic               scan_rise;
    logic               scan_fall;
    logic               sample;
    logic [FRAME_W-2:0] sr;
    logic [FRAME_W-1:0] frame_next;

    mu0_scan_clkgen #(.HALF(HALF)) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .en       (state != IDLE),
        .scan_clk (scan_clk),
        .rise     (scan_rise),
        .fall     (scan_fall)
    );

    // Sample only at the end of a pulse whose high phase was actually driven.
    assign sample = scan_fall && hi_seen;

    // The last bit goes straight from scan_out into the output registers, so
    // the shift register only needs to hold the first FRAME_W-1 bits.
    assign frame_next = {scan_out, sr};

    always_ff @(posedge clk) begin
        if (sample) begin
            sr <= frame_next[FRAME_W-1:1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            hi_seen    <= 1'b0;
            scan_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            snap_valid <= 1'b0;
            acc_q      <= '0;
            pc_q       <= '0;
            flags_q    <= '0;
        end else begin
            done <= 1'b0;
            if (scan_rise) begin
                hi_seen <= 1'b1;
            end else if (scan_fall) begin
                hi_seen <= 1'b0;
            end
            case (state)
                IDLE: begin
                    hi_seen <= 1'b0;
                    if (start) begin
                        state <= SYNC;
                        busy  <= 1'b1;
                        count <= '0;
                    end
                end
                SYNC: begin
                    if (sample) begin
                        scan_en <= 1'b1;
                        count   <= CNT_W'(1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sample) begin
                        if (count == LAST) begin
                            acc_q      <= frame_next[ACC_W-1:0];
                            pc_q       <= frame_next[ACC_W +: PC_W];
                            flags_q    <= frame_next[ACC_W+PC_W +: FLAG_W];
                            scan_en    <= 1'b0;
                            busy       <= 1'b0;
                            snap_valid <= 1'b1;
                            done       <= 1'b1;
                            count      <= '0;
                            state      <= IDLE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_scan_reader.sv
// Scoreboard bench for mu0_scan_reader: two instances (HALF=2 and HALF=1),
// each driven by a behavioural scanner; a negedge monitor checks every frame.
module tb_mu0_scan_reader;

    typedef struct packed {
        logic [15:0] acc;
        logic [11:0] pc;
        logic [1:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    // DUT A (HALF=2) signals
    logic        start_a, busy_a, done_a, snap_valid_a, scan_clk_a, scan_en_a, scan_out_a;
    logic [15:0] acc_a;
    logic [11:0] pc_a;
    logic [1:0]  flags_a;
    // DUT B (HALF=1) signals
    logic        start_b, busy_b, done_b, snap_valid_b, scan_clk_b, scan_en_b, scan_out_b;
    logic [15:0] acc_b;
    logic [11:0] pc_b;
    logic [1:0]  flags_b;

    exp_t sb_a[$];
    exp_t sb_b[$];

    mu0_scan_reader #(.ACC_W(16), .PC_W(12), .FLAG_W(2), .HALF(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
        .snap_valid(snap_valid_a), .acc_q(acc_a), .pc_q(pc_a), .flags_q(flags_a),
        .scan_clk(scan_clk_a), .scan_en(scan_en_a), .scan_out(scan_out_a)
    );

    mu0_scan_reader #(.ACC_W(16), .PC_W(12), .FLAG_W(2), .HALF(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .snap_valid(snap_valid_b), .acc_q(acc_b), .pc_q(pc_b), .flags_q(flags_b),
        .scan_clk(scan_clk_b), .scan_en(scan_en_b), .scan_out(scan_out_b)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Behavioural scanners; A can also be clocked externally to misalign its index.
    logic [29:0] frame_a = '0;
    logic [29:0] frame_b = '0;
    logic [4:0]  idx_a = '0;
    logic [4:0]  idx_b = '0;
    logic        ext_clk = 1'b0;
    logic        ext_en = 1'b0;
    wire         sc_clk_a = scan_clk_a | ext_clk;
    wire         sc_en_a  = scan_en_a | ext_en;

    assign scan_out_a = frame_a[idx_a];
    assign scan_out_b = frame_b[idx_b];

    initial forever begin
        @(posedge sc_clk_a);
        if (!sc_en_a) idx_a = 5'd0;
        else idx_a = (idx_a == 5'd29) ? 5'd0 : idx_a + 5'd1;
    end

    initial forever begin
        @(posedge scan_clk_b);
        if (!scan_en_b) idx_b = 5'd0;
        else idx_b = (idx_b == 5'd29) ? 5'd0 : idx_b + 5'd1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_done(input bit which, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(which ? done_b : done_a) && n < budget);
        chk(which ? "done_seen_b" : "done_seen_a", which ? done_b : done_a, 1);
    endtask

    // Monitor A
    logic busy_prev_a = 1'b0, done_prev_a = 1'b0, sclk_prev_a = 1'b0, snap_prev_a = 1'b0;
    int   t0_a = 0, pulses_a = 0;
    logic en_bad_a = 1'b0, sv_drop_a = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (busy_a && !busy_prev_a) begin
                t0_a = cyc; pulses_a = 0; en_bad_a = 1'b0;
            end
            if (scan_clk_a && !sclk_prev_a) begin
                pulses_a++;
                if (scan_en_a !== (pulses_a != 1)) en_bad_a = 1'b1;
            end
            if (snap_prev_a && !snap_valid_a) sv_drop_a = 1'b1;
            if (done_prev_a) chk("done_width_a", done_a, 0);
            if (done_a) begin
                if (sb_a.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_done_a: got done with empty scoreboard, expected none (t=%0t)", $time);
                end else begin
                    e = sb_a.pop_front();
                    chk("acc_a", acc_a, e.acc);
                    chk("pc_a", pc_a, e.pc);
                    chk("flags_a", flags_a, e.flags);
                    chk("snap_valid_a", snap_valid_a, 1);
                    chk("latency_a", cyc - t0_a, 120);
                    chk("pulses_a", pulses_a, 30);
                    chk("scan_en_pattern_a", en_bad_a, 0);
                end
            end
        end
        busy_prev_a = busy_a; done_prev_a = done_a;
        sclk_prev_a = scan_clk_a; snap_prev_a = snap_valid_a;
    end

    // Monitor B
    logic busy_prev_b = 1'b0, done_prev_b = 1'b0, sclk_prev_b = 1'b0;
    int   t0_b = 0, pulses_b = 0;
    logic en_bad_b = 1'b0, tog_bad_b = 1'b0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (busy_b && !busy_prev_b) begin
                t0_b = cyc; pulses_b = 0; en_bad_b = 1'b0; tog_bad_b = 1'b0;
            end
            if (busy_b && busy_prev_b && scan_clk_b == sclk_prev_b) tog_bad_b = 1'b1;
            if (scan_clk_b && !sclk_prev_b) begin
                pulses_b++;
                if (scan_en_b !== (pulses_b != 1)) en_bad_b = 1'b1;
            end
            if (done_prev_b) chk("done_width_b", done_b, 0);
            if (done_b) begin
                if (sb_b.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_done_b: got done with empty scoreboard, expected none (t=%0t)", $time);
                end else begin
                    e = sb_b.pop_front();
                    chk("acc_b", acc_b, e.acc);
                    chk("pc_b", pc_b, e.pc);
                    chk("flags_b", flags_b, e.flags);
                    chk("snap_valid_b", snap_valid_b, 1);
                    chk("latency_b", cyc - t0_b, 60);
                    chk("pulses_b", pulses_b, 30);
                    chk("scan_en_pattern_b", en_bad_b, 0);
                    chk("toggle_every_cycle_b", tog_bad_b, 0);
                end
            end
        end
        busy_prev_b = busy_b; done_prev_b = done_b; sclk_prev_b = scan_clk_b;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        start_a = 1'b0;
        start_b = 1'b0;

        // Reset with clock stopped: outputs must clear immediately
        #3 rst = 1'b1;
        #1;
        chk("rst_async_a", {busy_a, done_a, snap_valid_a, acc_a, pc_a, flags_a, scan_clk_a, scan_en_a}, 0);
        chk("rst_async_b", {busy_b, done_b, snap_valid_b, acc_b, pc_b, flags_b, scan_clk_b, scan_en_b}, 0);
        clk_run = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_quiet", {scan_clk_a, scan_en_a, scan_clk_b, scan_en_b}, 0);
        end

        // Basic frame
        frame_a = {2'b10, 12'hABC, 16'h1234};
        start_a = 1'b1;
        sb_a.push_back('{acc: 16'h1234, pc: 12'hABC, flags: 2'b10});
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 200);
        @(negedge clk);

        // Scanner index misaligned to 7 before the capture
        ext_en = 1'b1;
        repeat (8) begin
            #2 ext_clk = 1'b1;
            #2 ext_clk = 1'b0;
        end
        ext_en = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        sb_a.push_back('{acc: 16'h1234, pc: 12'hABC, flags: 2'b10});
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 200);
        @(negedge clk);

        // Back-to-back frames with start held, ignored mid-frame pulse
        frame_a = {2'b10, 12'hABC, 16'h0001};
        start_a = 1'b1;
        sb_a.push_back('{acc: 16'h0001, pc: 12'hABC, flags: 2'b10});
        wait_done(1'b0, 200);
        chk("idle_gap_busy", busy_a, 0);
        frame_a = {2'b10, 12'hABC, 16'hFFFF};
        sb_a.push_back('{acc: 16'hFFFF, pc: 12'hABC, flags: 2'b10});
        @(negedge clk);
        chk("b2b_restart_busy", busy_a, 1);
        repeat (30) @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 200);
        repeat (10) @(negedge clk);
        chk("no_extra_frame", busy_a, 0);
        chk("snap_valid_held", sv_drop_a, 0);

        // Reset in the middle of a capture
        frame_a = {2'b01, 12'h321, 16'hBEEF};
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (48) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_scan_clk", scan_clk_a, 0);
        chk("midrst_scan_en", scan_en_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_snap_valid", snap_valid_a, 0);
        chk("midrst_acc", acc_a, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        sb_a.push_back('{acc: 16'hBEEF, pc: 12'h321, flags: 2'b01});
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1'b0, 200);

        // HALF=1 instance
        frame_b = {2'b01, 12'h5A5, 16'hA5A5};
        start_b = 1'b1;
        sb_b.push_back('{acc: 16'hA5A5, pc: 12'h5A5, flags: 2'b01});
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1'b1, 100);
        @(negedge clk);
        frame_b = {2'b10, 12'h801, 16'h8001};
        start_b = 1'b1;
        sb_b.push_back('{acc: 16'h8001, pc: 12'h801, flags: 2'b10});
        @(negedge clk);
        start_b = 1'b0;
        wait_done(1'b1, 100);

        repeat (3) @(negedge clk);
        chk("sb_a_drained", sb_a.size(), 0);
        chk("sb_b_drained", sb_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
